// File: rtl/sd_interval_timer.sv
// sd_interval_timer: programmable interval timer for the SD host controller.
// A prescaler divides clk by (S+1). The main counter then counts 0..P, so
// expiries are (P+1)*(S+1) clocks apart. Two modes are supported:
// one-shot (ends in DONE with a sticky expired flag) and periodic (the main
// counter reloads to 0 on every expiry). period, prescale and mode are
// captured on start and are ignored at all other times.
module sd_interval_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic                  busy,
  output logic                  expired,
  output logic [WIDTH-1:0]      count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                state_q,   state_d;
  logic [PRESCALE_W-1:0] pre_q,     pre_d;
  logic [WIDTH-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]      per_q,     per_d;
  logic [PRESCALE_W-1:0] psc_q,     psc_d;
  logic                  mode_q,    mode_d;
  logic                  tick_q,    tick_d;
  logic                  busy_q,    busy_d;
  logic                  expired_q, expired_d;

  // Next-state logic. Priority order is stop > start > expiry.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    psc_d     = psc_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    tick_d    = 1'b0;
    if (stop) begin
      // Abort: the counters keep their values so count still shows where the
      // timer stopped.
      state_d   = ST_IDLE;
      expired_d = 1'b0;
    end else if (start) begin
      // (Re)arm: a start that lands on an expiry edge discards that expiry.
      per_d     = period;
      psc_d     = prescale;
      mode_d    = mode;
      cnt_d     = CNT_ZERO;
      pre_d     = PRE_ZERO;
      expired_d = 1'b0;
      state_d   = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pre_q == psc_q) begin
            pre_d = PRE_ZERO;
            if (cnt_q == per_q) begin
              tick_d = 1'b1;
              if (mode_q) begin
                cnt_d = CNT_ZERO;
              end else begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
              end
            end else begin
              // The counter stops at per_q, so an all-ones period cannot wrap.
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= PRE_ZERO;
      cnt_q     <= CNT_ZERO;
      per_q     <= CNT_ZERO;
      psc_q     <= PRE_ZERO;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      psc_q     <= psc_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign tick    = tick_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_sd_interval_timer.sv
// Testbench for sd_interval_timer.
// The stimulus process queues the tick it expects: the edge number at which
// the tick appears, plus the count value at that moment. A monitor then checks
// every tick the DUT produces against that queue. Status outputs are checked
// inline using hand-computed values.
module tb_sd_interval_timer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        tick;
  logic        busy;
  logic        expired;
  logic [15:0] count;

  int unsigned cyc;
  int          n_cmp;
  int          n_err;

  typedef struct {
    int unsigned edge_n;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  sd_interval_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .prescale (prescale),
    .tick     (tick),
    .busy     (busy),
    .expired  (expired),
    .count    (count)
  );

  // Clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges. At a falling edge, cyc is the number of the most
  // recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor. It reports expected ticks that never came, then matches each
  // observed tick against the front of the queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_tick: no tick seen, expected at edge %0d (now %0d)", exp_q[0].edge_n, cyc);
      void'(exp_q.pop_front());
    end
    if (tick !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
        if (count !== exp_q[0].cnt) begin
          n_err++;
          $display("FAIL tick_count: got %0h expected %0h at edge %0d", count, exp_q[0].cnt, cyc);
        end
        void'(exp_q.pop_front());
      end else begin
        n_err++;
        $display("FAIL unexpected_tick: tick=%b at edge %0d, expected none", tick, cyc);
      end
    end
  end

  task automatic push_tick(input int unsigned e, input logic [15:0] c);
    exp_t x;
    x.edge_n = e;
    x.cnt    = c;
    exp_q.push_back(x);
  endtask

  // Call at a falling edge. Waits until cyc reaches c.
  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a falling edge. Issues a start that the next rising edge (e0)
  // samples, then returns at the falling edge after e0.
  task automatic start_now(input logic m, input logic [15:0] p, input logic [7:0] s,
                           output int unsigned e0);
    mode     = m;
    period   = p;
    prescale = s;
    start    = 1'b1;
    e0       = cyc + 1;
    @(negedge clk);
    start    = 1'b0;
    mode     = ~m;
    period   = 16'h0009;
    prescale = 8'h07;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    int unsigned e1;
    cyc      = 0;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = 1'b0;
    period   = 16'h0000;
    prescale = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tick",    tick,    1'b0);
    check("rst_busy",    busy,    1'b0);
    check("rst_expired", expired, 1'b0);
    check("rst_count",   count,   16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // One-shot, P=3, S=0. Expiry at e0+4 with count held at 3.
    start_now(1'b0, 16'd3, 8'd0, e0);
    push_tick(e0 + 4, 16'd3);
    check("os_busy0",  busy,  1'b1);
    check("os_count0", count, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("os_count_step", count, k);
    end
    wait_until(e0 + 4);
    check("os_expired", expired, 1'b1);
    check("os_busy_done", busy, 1'b0);
    check("os_count_done", count, 16'd3);
    wait_until(e0 + 16);
    check("os_expired_hold", expired, 1'b1);
    check("os_count_hold", count, 16'd3);
    check("os_busy_hold", busy, 1'b0);

    // Periodic, P=4, S=1. A tick every 10 clocks, count never exceeds 4.
    start_now(1'b1, 16'd4, 8'd1, e0);
    for (int i = 1; i <= 5; i++) push_tick(e0 + 10 * i, 16'd0);
    check("pe_expired_clr", expired, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("pe_busy", busy, 1'b1);
      check("pe_count_le4", (count <= 16'd4), 1'b1);
    end
    stop_now();
    check("pe_stop_busy", busy, 1'b0);
    check("pe_stop_expired", expired, 1'b0);

    // Restart two clocks before expiry, with P changed from 5 to 2. The old
    // expiry at e0+6 must not appear; the new one is at e1+3.
    @(negedge clk);
    start_now(1'b0, 16'd5, 8'd0, e0);
    wait_until(e0 + 3);
    start_now(1'b0, 16'd2, 8'd0, e1);
    push_tick(e1 + 3, 16'd2);
    check("rs_count_clr", count, 16'd0);
    wait_until(e1 + 5);
    check("rs_expired", expired, 1'b1);
    check("rs_count", count, 16'd2);

    // start and stop together while running: stop wins, count holds at 1.
    start_now(1'b1, 16'd3, 8'd0, e0);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy, 1'b0);
    check("ss_expired", expired, 1'b0);
    check("ss_count", count, 16'd1);
    wait_until(e0 + 10);
    check("ss_busy_hold", busy, 1'b0);
    check("ss_count_hold", count, 16'd1);

    // A start that coincides with an expiry (P=2 expires at e0+3) gives no
    // tick at that edge. The new P=1 interval expires at e1+2.
    start_now(1'b0, 16'd2, 8'd0, e0);
    wait_until(e0 + 2);
    start_now(1'b0, 16'd1, 8'd0, e1);
    check("co_edge_align", e1, e0 + 3);
    push_tick(e1 + 2, 16'd1);
    check("co_busy", busy, 1'b1);
    check("co_expired", expired, 1'b0);
    wait_until(e1 + 3);
    check("co_expired_set", expired, 1'b1);

    // P=0, S=0, periodic: tick stays high every cycle until the stop.
    start_now(1'b1, 16'd0, 8'd0, e0);
    for (int i = 1; i <= 5; i++) push_tick(e0 + i, 16'd0);
    wait_until(e0 + 5);
    stop_now();
    check("p0_busy", busy, 1'b0);
    check("p0_tick_low", tick, 1'b0);

    // All-ones period: the first tick comes after 65536 clocks and count
    // returns to 0.
    @(negedge clk);
    start_now(1'b1, 16'hFFFF, 8'd0, e0);
    push_tick(e0 + 65536, 16'd0);
    wait_until(e0 + 65535);
    check("wr_count_max", count, 16'hFFFF);
    wait_until(e0 + 65536);
    check("wr_count_wrap", count, 16'h0000);
    check("wr_busy", busy, 1'b1);
    @(negedge clk);
    stop_now();

    // Asynchronous reset between clock edges while running at count 7.
    @(negedge clk);
    start_now(1'b0, 16'd20, 8'd0, e0);
    wait_until(e0 + 7);
    check("ar_count7", count, 16'd7);
    #2 reset = 1'b1;
    #1;
    check("ar_tick", tick, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_expired", expired, 1'b0);
    check("ar_count", count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("ar_idle_busy", busy, 1'b0);
    check("ar_idle_count", count, 16'd0);
    check("ar_idle_expired", expired, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
